// File: rtl/forwarding_unit.sv
// Operand forwarding and load-use stall detect between register read and execute.
// Define FORWARDING_OUT_REG_EN to register all outputs (1-cycle latency).
module forwarding_unit #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5
) (
  input  logic              h_clk,
  input  logic              h_rst,
  input  logic [DWIDTH-1:0] h_data_reg_rs1,
  input  logic [DWIDTH-1:0] h_data_reg_rs2,
  input  logic [AWIDTH-1:0] h_decoder_addr_rs1,
  input  logic [AWIDTH-1:0] h_decoder_addr_rs2,
  input  logic              h_i_valid_alu,
  input  logic              h_i_we_reg_alu,
  input  logic [AWIDTH-1:0] h_i_alu_addr_rd,
  input  logic [DWIDTH-1:0] h_i_alu_data_rd,
  input  logic              h_i_memoryaccess_ce,
  input  logic              h_i_we_reg_mem,
  input  logic [AWIDTH-1:0] h_i_addr_rd_mem,
  input  logic              h_i_wb_ce,
  input  logic [DWIDTH-1:0] h_i_data_rd_wb,
  output logic [DWIDTH-1:0] h_data_out_rs1,
  output logic [DWIDTH-1:0] h_data_out_rs2,
  output logic              h_alu_force_stall_out
);

  logic              w_alu_live;
  logic              w_mem_live;
  logic [DWIDTH-1:0] w_rs1_data;
  logic [DWIDTH-1:0] w_rs2_data;
  logic              w_rs1_stall;
  logic              w_rs2_stall;
  logic              w_stall;

  assign w_alu_live = h_i_we_reg_alu & h_i_memoryaccess_ce;
  assign w_mem_live = h_i_we_reg_mem & h_i_wb_ce;

  // ALU stage holds the younger instruction, so it is checked first.
  function automatic logic [DWIDTH:0] f_sel(
    input logic [AWIDTH-1:0] a,
    input logic [DWIDTH-1:0] rf
  );
    logic w_zero;
    logic w_alu_hit;
    logic w_mem_hit;
    w_zero    = (a == '0);
    w_alu_hit = w_alu_live & (h_i_alu_addr_rd == a);
    w_mem_hit = w_mem_live & (h_i_addr_rd_mem == a);
    priority case (1'b1)
      w_zero:    f_sel = '0;
      w_alu_hit: f_sel = h_i_valid_alu ?
                         {1'b0, h_i_alu_data_rd} :
                         {1'b1, rf};
      w_mem_hit: f_sel = {1'b0, h_i_data_rd_wb};
      default:   f_sel = {1'b0, rf};
    endcase
  endfunction

  always_comb begin
    {w_rs1_stall, w_rs1_data} =
      f_sel(h_decoder_addr_rs1, h_data_reg_rs1);
    {w_rs2_stall, w_rs2_data} =
      f_sel(h_decoder_addr_rs2, h_data_reg_rs2);
  end

  assign w_stall = w_rs1_stall | w_rs2_stall;

`ifdef FORWARDING_OUT_REG_EN
  logic [DWIDTH-1:0] r_rs1;
  logic [DWIDTH-1:0] r_rs2;
  logic              r_stall;

  always_ff @(posedge h_clk) begin
    if (h_rst) begin
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_stall <= 1'b0;
    end else begin
      r_rs1   <= w_rs1_data;
      r_rs2   <= w_rs2_data;
      r_stall <= w_stall;
    end
  end

  assign h_data_out_rs1        = r_rs1;
  assign h_data_out_rs2        = r_rs2;
  assign h_alu_force_stall_out = r_stall;
`else
  logic w_unused;
  assign w_unused = h_clk ^ h_rst;

  assign h_data_out_rs1        = w_rs1_data;
  assign h_data_out_rs2        = w_rs2_data;
  assign h_alu_force_stall_out = w_stall;
`endif

endmodule

// File: tb/tb_forwarding_unit.sv
// Bench for forwarding_unit: directed cases then random traffic vs a model.
// Works with or without FORWARDING_OUT_REG_EN defined.
module tb_forwarding_unit;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] reg1, reg2;
  logic [AW-1:0] rs1, rs2;
  logic          valid_alu, we_alu, mem_ce;
  logic [AW-1:0] alu_rd, mem_rd;
  logic [DW-1:0] alu_data, wb_data;
  logic          we_mem, wb_ce;
  logic [DW-1:0] out1, out2;
  logic          stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  forwarding_unit #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .h_clk                 (clk),
    .h_rst                 (rst),
    .h_data_reg_rs1        (reg1),
    .h_data_reg_rs2        (reg2),
    .h_decoder_addr_rs1    (rs1),
    .h_decoder_addr_rs2    (rs2),
    .h_i_valid_alu         (valid_alu),
    .h_i_we_reg_alu        (we_alu),
    .h_i_alu_addr_rd       (alu_rd),
    .h_i_alu_data_rd       (alu_data),
    .h_i_memoryaccess_ce   (mem_ce),
    .h_i_we_reg_mem        (we_mem),
    .h_i_addr_rd_mem       (mem_rd),
    .h_i_wb_ce             (wb_ce),
    .h_i_data_rd_wb        (wb_data),
    .h_data_out_rs1        (out1),
    .h_data_out_rs2        (out2),
    .h_alu_force_stall_out (stall)
  );

  // Producers listed youngest first; first live writer of rs decides.
  function automatic logic [DW:0] ref_op(
    input logic [AW-1:0] rs,
    input logic [DW-1:0] regv
  );
    logic [AW-1:0] rd [2];
    logic          live [2];
    logic          rdy [2];
    logic [DW-1:0] d [2];
    rd[0] = alu_rd; live[0] = we_alu && mem_ce;
    rdy[0] = valid_alu; d[0] = alu_data;
    rd[1] = mem_rd; live[1] = we_mem && wb_ce;
    rdy[1] = 1'b1; d[1] = wb_data;
    if (rs == 0) return '0;
    for (int i = 0; i < 2; i++)
      if (live[i] && rd[i] == rs)
        return rdy[i] ? {1'b0, d[i]} : {1'b1, regv};
    return {1'b0, regv};
  endfunction

  task automatic chk(input string tag,
                     input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    logic [DW:0] e1, e2;
    e1 = ref_op(rs1, reg1);
    e2 = ref_op(rs2, reg2);
    chk({tag, "_rs1"}, out1, e1[DW-1:0]);
    chk({tag, "_rs2"}, out2, e2[DW-1:0]);
    chk({tag, "_stall"}, {31'd0, stall},
        {31'd0, e1[DW] | e2[DW]});
  endtask

  task automatic step();
`ifdef FORWARDING_OUT_REG_EN
    @(posedge clk);
`endif
    #1;
  endtask

  task automatic clear();
    rs1 = 0; rs2 = 0; reg1 = 100; reg2 = 88;
    valid_alu = 0; we_alu = 0; mem_ce = 0;
    alu_rd = 0; alu_data = 0;
    we_mem = 0; wb_ce = 0; mem_rd = 0; wb_data = 0;
  endtask

  initial begin
    rst = 1'b1;
    clear();
    reg1 = 32'hdead; reg2 = 32'hbeef; rs1 = 3; rs2 = 4;
    step();
`ifdef FORWARDING_OUT_REG_EN
    chk("reset_rs1", out1, 0);
    chk("reset_rs2", out2, 0);
    chk("reset_stall", {31'd0, stall}, 0);
`else
    chk("rst_ignored_rs1", out1, 32'hdead);
    chk("rst_ignored_rs2", out2, 32'hbeef);
`endif
    rst = 1'b0;

    clear();
    alu_data = 109; we_alu = 1; mem_ce = 1;
    step();
    chk("x0_rs1", out1, 0);
    chk("x0_rs2", out2, 0);
    chk("x0_stall", {31'd0, stall}, 0);

    rs1 = 10; rs2 = 12;
    step();
    chk("rf_rs1", out1, 100);
    chk("rf_rs2", out2, 88);
    chk("rf_stall", {31'd0, stall}, 0);

    alu_rd = 10; valid_alu = 0;
    step();
    chk("ld1_stall", {31'd0, stall}, 1);
    chk("ld1_rs1", out1, 100);
    valid_alu = 1;
    step();
    chk("alu1_rs1", out1, 109);
    chk("alu1_stall", {31'd0, stall}, 0);

    alu_rd = 12; alu_data = 111; valid_alu = 0;
    step();
    chk("ld2_stall", {31'd0, stall}, 1);
    chk("ld2_rs2", out2, 88);
    valid_alu = 1;
    step();
    chk("alu2_rs2", out2, 111);
    chk("alu2_stall", {31'd0, stall}, 0);

    clear();
    rs1 = 7; mem_rd = 7; we_mem = 1; wb_ce = 1; wb_data = 55;
    step();
    chk("mem_rs1", out1, 55);
    wb_ce = 0;
    step();
    chk("mem_off_rs1", out1, 100);

    clear();
    rs1 = 5; alu_rd = 5; we_alu = 1; mem_ce = 1; valid_alu = 1;
    alu_data = 1; mem_rd = 5; we_mem = 1; wb_ce = 1; wb_data = 2;
    step();
    chk("prio_rs1", out1, 1);

    alu_data = 9;
    #1;
`ifdef FORWARDING_OUT_REG_EN
    chk("latency_hold", out1, 1);
    step();
    chk("latency_upd", out1, 9);
    rst = 1'b1;
    step();
    chk("midrst_rs1", out1, 0);
    chk("midrst_rs2", out2, 0);
    chk("midrst_stall", {31'd0, stall}, 0);
    rst = 1'b0;
`else
    chk("comb_upd", out1, 9);
`endif

    for (int n = 0; n < 300; n++) begin
      rs1 = AW'($urandom_range(0, 3));
      rs2 = AW'($urandom_range(0, 3));
      reg1 = $urandom; reg2 = $urandom;
      alu_rd = AW'($urandom_range(0, 3));
      mem_rd = AW'($urandom_range(0, 3));
      alu_data = $urandom; wb_data = $urandom;
      valid_alu = 1'($urandom); we_alu = 1'($urandom);
      mem_ce = 1'($urandom); we_mem = 1'($urandom);
      wb_ce = 1'($urandom);
      step();
      chk_model("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
